// File: rtl/integer_seven_segment_display.sv
// Three-digit multiplexed seven-segment display for an 8-bit unsigned value.
// A free-running shift-and-add-3 converter feeds a refresh-paced digit mux.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_LOAD  | sample the input value, clear the BCD scratch register
//   ST_SHIFT | eight adjust-then-shift steps on {scratch, binary}
//   ST_DONE  | publish scratch to bcd_data, then restart at ST_LOAD
module integer_seven_segment_display #(
   parameter int DIGIT_PERIOD_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] integer_to_be_displayed,
   output logic       led1_control_signal,
   output logic       led2_control_signal,
   output logic       led3_control_signal,
   output logic       led_change_tick,
   output logic [7:0] display_bits
);

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int CW = (DIGIT_PERIOD_CYCLES > 1) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;
   localparam logic [CW-1:0] REFRESH_LAST = CW'(DIGIT_PERIOD_CYCLES - 1);

   logic [1:0]    state;
   logic [2:0]    shift_cnt;
   logic [7:0]    bin_sr;
   logic [11:0]   scratch;
   logic [11:0]   adjusted;
   logic [19:0]   shifted;
   logic [11:0]   bcd_data;

   logic [CW-1:0] refresh_cnt;
   logic [1:0]    digit_idx;
   logic [1:0]    next_idx;
   logic [3:0]    next_nibble;

   function automatic logic [11:0] add3_nibbles(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Active-low segments {dp,g,f,e,d,c,b,a}; non-decimal nibbles blank.
   function automatic logic [7:0] seg_decode(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   always_comb begin
      adjusted = add3_nibbles(scratch);
      shifted  = {adjusted, bin_sr} << 1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_LOAD;
         shift_cnt <= 3'd0;
         bin_sr    <= 8'd0;
         scratch   <= 12'd0;
         bcd_data  <= 12'd0;
      end else begin
         case (state)
            ST_LOAD: begin
               bin_sr    <= integer_to_be_displayed;
               scratch   <= 12'd0;
               shift_cnt <= 3'd0;
               state     <= ST_SHIFT;
            end
            ST_SHIFT: begin
               scratch   <= shifted[19:8];
               bin_sr    <= shifted[7:0];
               shift_cnt <= shift_cnt + 3'd1;
               if (shift_cnt == 3'd7) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               bcd_data <= scratch;
               state    <= ST_LOAD;
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

   assign led_change_tick = (refresh_cnt == REFRESH_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_cnt <= '0;
      end else if (led_change_tick) begin
         refresh_cnt <= '0;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   always_comb begin
      next_idx = (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      case (next_idx)
         2'd0:    next_nibble = bcd_data[11:8];
         2'd1:    next_nibble = bcd_data[7:4];
         default: next_nibble = bcd_data[3:0];
      endcase
   end

   // Outputs change only at slot boundaries, so a conversion finishing
   // mid-slot shows up at the following digit change.
   always_ff @(posedge clk) begin
      if (reset) begin
         digit_idx           <= 2'd0;
         led1_control_signal <= 1'b1;
         led2_control_signal <= 1'b0;
         led3_control_signal <= 1'b0;
         display_bits        <= 8'hC0;
      end else if (led_change_tick) begin
         digit_idx           <= next_idx;
         led1_control_signal <= (next_idx == 2'd0);
         led2_control_signal <= (next_idx == 2'd1);
         led3_control_signal <= (next_idx == 2'd2);
         display_bits        <= seg_decode(next_nibble);
      end
   end

endmodule

// File: tb/tb_integer_seven_segment_display.sv
// Bench for integer_seven_segment_display: directed scenarios plus random
// inputs, compared every cycle against an arithmetic timing model.
module tb_integer_seven_segment_display;

   localparam int P = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] value = 8'd0;
   logic       led1, led2, led3, tick;
   logic [7:0] disp;

   int checks = 0;
   int errors = 0;

   integer_seven_segment_display #(.DIGIT_PERIOD_CYCLES(P)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .integer_to_be_displayed (value),
      .led1_control_signal     (led1),
      .led2_control_signal     (led2),
      .led3_control_signal     (led3),
      .led_change_tick         (tick),
      .display_bits            (disp)
   );

   always #5 clk = ~clk;

   // Reference model: t = cycles since reset release, phase = t mod 10.
   int         t = 0;
   logic [7:0] m_samp = 8'd0;
   logic [11:0] m_bcd = 12'd0;
   int         m_idx = 0;
   logic [7:0] m_disp = 8'hC0;
   logic [2:0] m_leds = 3'b100;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] seg_of(input logic [3:0] n);
      logic [7:0] tab [0:9];
      tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      return (n <= 4'd9) ? tab[n] : 8'hFF;
   endfunction

   function automatic logic [3:0] digit_of(input logic [11:0] b, input int idx);
      return (idx == 0) ? b[11:8] : (idx == 1) ? b[7:4] : b[3:0];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         t      <= 0;
         m_bcd  <= 12'd0;
         m_idx  <= 0;
         m_disp <= 8'hC0;
         m_leds <= 3'b100;
      end else begin
         t <= t + 1;
         if (t % 10 == 0) m_samp <= value;
         if (t % 10 == 9) m_bcd <= to_bcd(int'(m_samp));
         if (t % P == P - 1) begin
            m_idx  <= (m_idx + 1) % 3;
            m_disp <= seg_of(digit_of(m_bcd, (m_idx + 1) % 3));
            m_leds <= 3'b100 >> ((m_idx + 1) % 3);
         end
      end
   end

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic check_model();
      chk("leds", 12'({led1, led2, led3}), 12'(m_leds));
      chk("tick", 12'(tick), 12'(t % P == P - 1));
      chk("disp", 12'(disp), 12'(m_disp));
      chk("bcd", dut.bcd_data, m_bcd);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         check_model();
      end
   endtask

   task automatic check_reset_values();
      chk("rst_leds", 12'({led1, led2, led3}), 12'b100);
      chk("rst_tick", 12'(tick), 12'd0);
      chk("rst_disp", 12'(disp), 12'h0C0);
      chk("rst_bcd", dut.bcd_data, 12'h000);
   endtask

   task automatic restart(input logic [7:0] v);
      reset = 1'b1;
      value = v;
      step(1);
      reset = 1'b0;
   endtask

   initial begin
      value = 8'($urandom);
      step(3);
      check_reset_values();

      restart(8'd123);
      step(100);

      value = 8'd255;
      step(40);
      value = 8'd0;
      step(40);

      restart(8'd5);
      step(10);
      chk("bcd_005", dut.bcd_data, 12'h005);
      step(30);

      restart(8'd200);
      step(3);
      value = 8'd37;
      step(7);
      chk("bcd_200", dut.bcd_data, 12'h200);
      step(10);
      chk("bcd_037", dut.bcd_data, 12'h037);
      step(20);

      restart(8'd99);
      step(5);
      reset = 1'b1;
      step(1);
      check_reset_values();
      reset = 1'b0;
      step(9);
      chk("bcd_pre099", dut.bcd_data, 12'h000);
      step(1);
      chk("bcd_099", dut.bcd_data, 12'h099);
      step(20);

      for (int i = 0; i < 40; i++) begin
         value = 8'($urandom);
         step(int'($urandom_range(5, 40)));
         if ($urandom_range(0, 9) == 0) begin
            reset = 1'b1;
            step(1);
            check_reset_values();
            reset = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
